// File: rtl/lcd_pwm_ctrl.sv
// lcd_pwm_ctrl
// Multi-channel PWM generator for LCD backlight and contrast control,
// attached to the Avalon-MM bus as a zero-wait-state slave. All channels
// share one period counter. Period and duty writes land in staged
// registers. They are copied to the active registers only at a period
// boundary, or on every cycle while stopped, so the outputs never glitch.
//
// Optional feature: define LCD_PWM_FADE_EN to make each active duty step
// by 1 toward its staged value at each boundary instead of jumping to it.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   address      word address (0 CTRL, 1 PERIOD, 2 STATUS, 4+i DUTY[i])
//   chipselect   slave select
//   write_n      active-low write strobe
//   writedata    write data; bits above the field width are ignored
//   readdata     combinational readback of the addressed register
//   out_port     registered PWM outputs, one per channel
//   period_tick  registered one-cycle pulse per period boundary

module lcd_pwm_ctrl #(
    parameter int CHANNELS       = 2,
    parameter int WIDTH          = 16,
    parameter int DEFAULT_PERIOD = 999
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [CHANNELS-1:0] out_port,
    output logic                period_tick
);

    localparam logic [WIDTH-1:0] RESET_PERIOD = WIDTH'(DEFAULT_PERIOD);

    logic             run;
    logic             inv;
    logic [WIDTH-1:0] period_stg;
    logic [WIDTH-1:0] period_act;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty_stg [CHANNELS];
    logic [WIDTH-1:0] duty_act [CHANNELS];
    logic             wr_en;
    logic [WIDTH-1:0] wr_val;
    logic             boundary;
    logic             pending;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wr_val       = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata[31:WIDTH];

    // The wrap cycle of the counter; only meaningful while running.
    assign boundary = run && (cnt == period_act);

    // Bus-visible staged registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            run        <= 1'b0;
            inv        <= 1'b0;
            period_stg <= RESET_PERIOD;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_stg[i] <= '0;
            end
        end else if (wr_en) begin
            if (address == 4'd0) begin
                run <= writedata[0];
                inv <= writedata[1];
            end
            if (address == 4'd1) begin
                period_stg <= wr_val;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (address == 4'(4 + i)) begin
                    duty_stg[i] <= wr_val;
                end
            end
        end
    end

    // Shared counter and active copies. The boundary reads the staged
    // registers before this edge's write, so a write landing on a boundary
    // waits for the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            period_act <= RESET_PERIOD;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_act[i] <= '0;
            end
        end else if (!run) begin
            cnt        <= '0;
            period_act <= period_stg;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_act[i] <= duty_stg[i];
            end
        end else if (boundary) begin
            cnt        <= '0;
            period_act <= period_stg;
            for (int i = 0; i < CHANNELS; i++) begin
`ifdef LCD_PWM_FADE_EN
                if (duty_act[i] < duty_stg[i]) begin
                    duty_act[i] <= duty_act[i] + 1'b1;
                end else if (duty_act[i] > duty_stg[i]) begin
                    duty_act[i] <= duty_act[i] - 1'b1;
                end
`else
                duty_act[i] <= duty_stg[i];
`endif
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Outputs are registered from the current counter state, so they lag
    // it by one cycle. A duty above the period never matches, giving a
    // constant-high output.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_port    <= '0;
            period_tick <= 1'b0;
        end else begin
            period_tick <= boundary;
            for (int i = 0; i < CHANNELS; i++) begin
                out_port[i] <= run ? ((cnt < duty_act[i]) ^ inv) : inv;
            end
        end
    end

    // PENDING: some staged value has not yet reached its active copy.
    always_comb begin
        pending = (period_stg != period_act);
        for (int i = 0; i < CHANNELS; i++) begin
            if (duty_stg[i] != duty_act[i]) begin
                pending = 1'b1;
            end
        end
    end

    // Read mux; staged values are returned, not active ones.
    always_comb begin
        readdata = '0;
        case (address)
            4'd0: readdata[1:0] = {inv, run};
            4'd1: readdata[WIDTH-1:0] = period_stg;
            4'd2: readdata[0] = pending;
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (address == 4'(4 + i)) begin
                        readdata[WIDTH-1:0] = duty_stg[i];
                    end
                end
            end
        endcase
    end

endmodule

// File: doc/lcd_pwm_ctrl.md
# lcd_pwm_ctrl

Multi-channel, memory-mapped PWM generator for LCD backlight and contrast control, and the parametrised successor to the single-bit LCD PWM output port. It sits on the Avalon-MM peripheral bus as a zero-wait-state slave. It drives CHANNELS PWM outputs from one shared period counter. Duty and period updates are double-buffered and take effect only at period boundaries, so the outputs never glitch.

## Interface
Parameters:
- CHANNELS, 2: number of PWM outputs, 1..8.
- WIDTH, 16: counter, period and duty width, 2..31.
- DEFAULT_PERIOD, 999: reset value of the period register. The period is PERIOD+1 clocks.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  4  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write needs chipselect=1 and write_n=0.
- writedata  in  32  write data; bits above the field width are ignored.
- readdata  out  32  combinational read mux of address; unused bits are 0.
- out_port  out  CHANNELS  registered PWM outputs.
- period_tick  out  1  registered one-cycle pulse at each period boundary.

## Operation
Register map:
- 0 CTRL (rw): bit0 RUN, bit1 INV (inverts all outputs).
- 1 PERIOD (rw): the staged period value.
- 2 STATUS (ro): bit0 PENDING. PENDING=1 while any staged value differs from its active copy.
- 4+i DUTY[i] (rw), i < CHANNELS: the staged duty value.
- All other addresses read 0; writes to them are ignored.

Readback:
- PERIOD and DUTY read back the staged value, not the active value.

Counter and outputs:
- The counter cnt runs from 0 up to period_act, then wraps to 0.
- The wrap cycle is a boundary. At a boundary: period_act ← PERIOD, duty_act[i] ← DUTY[i], and period_tick pulses.
- Each output is out_port[i] = (cnt < duty_act[i]) XOR INV.
  - DUTY=0 gives constant low.
  - DUTY > period_act gives constant high; there is no wrap or overflow into low.
- When RUN=0:
  - cnt is held at 0, period_tick is 0, and out_port = {CHANNELS{INV}}.
  - Staged values copy to active every cycle, so PENDING=0 after one cycle.
- On a RUN rising edge, counting starts at cnt=0 with the values already active.
- The compare is unsigned, WIDTH bits. PERIOD=0 gives a 1-cycle period: a boundary every cycle, and outputs are constant.

## Timing
- A register write takes effect at the clock edge ending the write cycle. Readback returns the new value in the next cycle.
- out_port and period_tick lag the counter state by exactly one cycle.
- A write in the same cycle as a boundary:
  - The boundary loads the pre-write staged value.
  - The new value goes active at the following boundary.
  - PENDING stays 1 until then.
- Latency from a write to the output change is at most period_act+2 cycles while RUN=1, and 2 cycles while RUN=0.
- Reset values:
  - out_port=0, period_tick=0, cnt=0.
  - CTRL=0.
  - PERIOD and period_act = DEFAULT_PERIOD.
  - All DUTY and duty_act = 0.
  - PENDING=0.
- Reset asserted mid-period forces all of the above on the next edge. No partial period completes.

## Configuration
- LCD_PWM_FADE_EN defined:
  - At each boundary, each duty_act[i] steps by 1 toward DUTY[i] instead of loading it directly.
  - PENDING stays 1 until every duty_act equals its staged value.
  - period_act still loads directly.
  - With RUN=0, values still load directly.
- LCD_PWM_FADE_EN undefined: duty_act loads directly at the boundary, as described above.

## Test plan
- Reset, then read every register → CTRL=0, PERIOD=999, DUTY=0, STATUS=0; out_port=0.
- PERIOD=9, DUTY[0]=3, DUTY[1]=10, RUN=1 → out_port[0] high 3 of every 10 cycles; out_port[1] constant high; period_tick every 10 cycles.
- While running with DUTY[0]=3, write DUTY[0]=7 mid-period → the current period still shows 3 high cycles and the next shows 7; STATUS=1 until the boundary.
- Write DUTY[0] in the same cycle as a boundary → the change appears one period later; no short or long pulse.
- INV=1 with RUN=0 → out_port all ones. Assert reset mid-period → outputs 0 and the counter restarts at 0.
- With LCD_PWM_FADE_EN: DUTY[0] from 0 to 5, PERIOD=9 → high time grows 1, 2, 3, 4, 5 over consecutive periods; STATUS clears after the 5th boundary.
